// File: rtl/wrapper_sha256_job_ctrl.sv
// ---------------------------------------------------------------------------
// wrapper_sha256_job_ctrl
//
// Purpose:
//   Per-message sequencer that sits between the AHB packet constructor and
//   the sha256_stream engine. A job descriptor gives the padded message
//   length in bits. The controller converts that length into a 512-bit block
//   count and passes exactly that many blocks through to the engine. It
//   forces the engine's last flag on the final block, then waits for the
//   digest. When the digest arrives it raises a one-cycle done pulse and
//   counts the completed job. It also drives the DMA input and output
//   request lines.
//
// Ports:
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   cfg_size/valid/ready job descriptor handshake (message length in bits)
//   src_valid/last/ready block stream from the packet constructor
//   eng_valid/last/ready block stream to the sha256 engine
//   digest_valid         single-cycle pulse: final digest produced
//   out_fifo_level       output FIFO occupancy
//   ctrl_abort           soft abort of the current job
//   err_clear            clears the sticky error flags
//   in_data_req          DMA input request (registered)
//   out_data_req         DMA output request (registered)
//   busy, done_pulse     job status
//   jobs_done            completed-job counter, wraps
//   err_last_mismatch    sticky: src_last disagreed with the block count
//   err_spurious_digest  sticky: digest_valid seen while idle
// ---------------------------------------------------------------------------
module wrapper_sha256_job_ctrl #(
    parameter int CFGSIZEWIDTH = 64,
    parameter int FIFOLVLWIDTH = 3,
    parameter int OUTREQTHRESH = 1,
    parameter int JOBCNTWIDTH  = 16
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic [CFGSIZEWIDTH-1:0] cfg_size,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic                    src_valid,
    input  logic                    src_last,
    output logic                    src_ready,
    output logic                    eng_valid,
    output logic                    eng_last,
    input  logic                    eng_ready,
    input  logic                    digest_valid,
    input  logic [FIFOLVLWIDTH-1:0] out_fifo_level,
    input  logic                    ctrl_abort,
    input  logic                    err_clear,
    output logic                    in_data_req,
    output logic                    out_data_req,
    output logic                    busy,
    output logic                    done_pulse,
    output logic [JOBCNTWIDTH-1:0]  jobs_done,
    output logic                    err_last_mismatch,
    output logic                    err_spurious_digest
);

    // The counter is one bit wider than cfg_size[MSB:9], so rounding up to a
    // whole block can never overflow it.
    localparam int REMW = CFGSIZEWIDTH - 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_WAIT_DIGEST,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [REMW-1:0]         remaining_q, remaining_d;
    logic [JOBCNTWIDTH-1:0]  jobs_done_q, jobs_done_d;
    logic                    err_last_q, err_last_d;
    logic                    err_spur_q, err_spur_d;
    logic                    in_req_q, in_req_d;
    logic                    out_req_q, out_req_d;

    logic [REMW-1:0]         blocks_raw;
    logic [REMW-1:0]         blocks;
    logic                    handshake;
    logic                    rem_is_one;
    logic                    set_last_err;
    logic                    set_spur_err;

    // Ceiling of size/512. A zero-length message still hashes one
    // (padding-only) block.
    assign blocks_raw = {1'b0, cfg_size[CFGSIZEWIDTH-1:9]}
                      + {{(REMW-1){1'b0}}, |cfg_size[8:0]};
    assign blocks     = (blocks_raw == '0) ? {{(REMW-1){1'b0}}, 1'b1} : blocks_raw;

    assign handshake  = src_valid & eng_ready;
    assign rem_is_one = (remaining_q == {{(REMW-1){1'b0}}, 1'b1});

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        jobs_done_d  = jobs_done_q;
        set_last_err = 1'b0;
        set_spur_err = 1'b0;
        cfg_ready    = 1'b0;
        src_ready    = 1'b0;
        eng_valid    = 1'b0;
        eng_last     = 1'b0;
        busy         = 1'b0;
        done_pulse   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (digest_valid) begin
                    set_spur_err = 1'b1;
                end
                if (cfg_valid) begin
                    remaining_d = blocks;
                    state_d     = ST_STREAM;
                end
            end

            ST_STREAM: begin
                busy      = 1'b1;
                eng_valid = src_valid;
                src_ready = eng_ready;
                // The count is authoritative: src_last is only checked.
                eng_last  = rem_is_one;
                if (handshake) begin
                    remaining_d = remaining_q - 1'b1;
                    if (src_last != rem_is_one) begin
                        set_last_err = 1'b1;
                    end
                    if (rem_is_one) begin
                        state_d = digest_valid ? ST_DONE : ST_WAIT_DIGEST;
                    end
                end
                // Abort overrides; a handshake in this cycle has already
                // been delivered to the engine.
                if (ctrl_abort) begin
                    remaining_d = '0;
                    state_d     = ST_IDLE;
                end
            end

            ST_WAIT_DIGEST: begin
                busy = 1'b1;
                if (digest_valid) begin
                    state_d = ST_DONE;
                end
                if (ctrl_abort) begin
                    remaining_d = '0;
                    state_d     = ST_IDLE;
                end
            end

            ST_DONE: begin
                busy        = 1'b1;
                done_pulse  = 1'b1;
                jobs_done_d = jobs_done_q + 1'b1;
                state_d     = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A set event in the same cycle takes priority over a clear.
        err_last_d = set_last_err | (err_last_q & ~err_clear);
        err_spur_d = set_spur_err | (err_spur_q & ~err_clear);

        in_req_d  = (state_q == ST_STREAM) & ~src_valid & (remaining_q != '0);
        out_req_d = (out_fifo_level >= FIFOLVLWIDTH'(OUTREQTHRESH));
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            jobs_done_q <= '0;
            err_last_q  <= 1'b0;
            err_spur_q  <= 1'b0;
            in_req_q    <= 1'b0;
            out_req_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            jobs_done_q <= jobs_done_d;
            err_last_q  <= err_last_d;
            err_spur_q  <= err_spur_d;
            in_req_q    <= in_req_d;
            out_req_q   <= out_req_d;
        end
    end

    assign in_data_req         = in_req_q;
    assign out_data_req        = out_req_q;
    assign jobs_done           = jobs_done_q;
    assign err_last_mismatch   = err_last_q;
    assign err_spurious_digest = err_spur_q;

endmodule

// File: tb/tb_wrapper_sha256_job_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wrapper_sha256_job_ctrl
//
// Purpose:
//   Self-checking bench for wrapper_sha256_job_ctrl. Inputs are driven on the
//   falling edge and outputs are sampled 1ns later, so combinational outputs
//   reflect the driven inputs and registered outputs reflect the previous
//   rising edge. The expected block count is ceil(size/512) (minimum 1),
//   computed arithmetically. Expected job count and error flags are kept as
//   plain model variables.
// ---------------------------------------------------------------------------
module tb_wrapper_sha256_job_ctrl;

    localparam int CFGSIZEWIDTH = 64;
    localparam int FIFOLVLWIDTH = 3;
    localparam int OUTREQTHRESH = 1;
    localparam int JOBCNTWIDTH  = 16;

    logic                    HCLK = 1'b0;
    logic                    HRESETn;
    logic [CFGSIZEWIDTH-1:0] cfg_size;
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic                    src_valid;
    logic                    src_last;
    logic                    src_ready;
    logic                    eng_valid;
    logic                    eng_last;
    logic                    eng_ready;
    logic                    digest_valid;
    logic [FIFOLVLWIDTH-1:0] out_fifo_level;
    logic                    ctrl_abort;
    logic                    err_clear;
    logic                    in_data_req;
    logic                    out_data_req;
    logic                    busy;
    logic                    done_pulse;
    logic [JOBCNTWIDTH-1:0]  jobs_done;
    logic                    err_last_mismatch;
    logic                    err_spurious_digest;

    int nvec = 0;
    int nerr = 0;

    // Reference model state
    int exp_jobs     = 0;
    bit exp_err_last = 0;
    bit exp_err_spur = 0;

    always #5 HCLK = ~HCLK;

    wrapper_sha256_job_ctrl #(
        .CFGSIZEWIDTH(CFGSIZEWIDTH),
        .FIFOLVLWIDTH(FIFOLVLWIDTH),
        .OUTREQTHRESH(OUTREQTHRESH),
        .JOBCNTWIDTH (JOBCNTWIDTH)
    ) dut (
        .HCLK               (HCLK),
        .HRESETn            (HRESETn),
        .cfg_size           (cfg_size),
        .cfg_valid          (cfg_valid),
        .cfg_ready          (cfg_ready),
        .src_valid          (src_valid),
        .src_last           (src_last),
        .src_ready          (src_ready),
        .eng_valid          (eng_valid),
        .eng_last           (eng_last),
        .eng_ready          (eng_ready),
        .digest_valid       (digest_valid),
        .out_fifo_level     (out_fifo_level),
        .ctrl_abort         (ctrl_abort),
        .err_clear          (err_clear),
        .in_data_req        (in_data_req),
        .out_data_req       (out_data_req),
        .busy               (busy),
        .done_pulse         (done_pulse),
        .jobs_done          (jobs_done),
        .err_last_mismatch  (err_last_mismatch),
        .err_spurious_digest(err_spurious_digest)
    );

    function automatic int model_blocks(input longint unsigned size);
        longint unsigned b;
        b = (size + 511) / 512;
        if (b == 0) b = 1;
        return int'(b);
    endfunction

    task automatic idle_inputs();
        cfg_valid    = 1'b0;
        src_valid    = 1'b0;
        src_last     = 1'b0;
        eng_ready    = 1'b0;
        digest_valid = 1'b0;
        ctrl_abort   = 1'b0;
        err_clear    = 1'b0;
    endtask

    task automatic tick();
        @(negedge HCLK);
    endtask

    // Runs one complete job and checks the pass-through, the last flag,
    // digest gating, the done pulse and the job counter along the way.
    task automatic do_job(input longint unsigned size, input int max_stall,
                          input int mism_idx, input int digest_gap,
                          input bit coincident);
        int  nblk;
        int  stalls;
        bit  want_last;
        tick();
        idle_inputs();
        cfg_size  = size;
        cfg_valid = 1'b1;
        #1;
        nvec++;
        if (cfg_ready !== 1'b1) begin
            nerr++;
            $display("FAIL job_cfg_ready size=%0d got=%b want=1", size, cfg_ready);
        end
        nblk = model_blocks(size);
        for (int i = 0; i < nblk; i++) begin
            want_last = (i == nblk - 1);
            stalls = (max_stall > 0) ? $urandom_range(0, max_stall) : 0;
            for (int s = 0; s < stalls; s++) begin
                tick();
                idle_inputs();
                src_valid = 1'b1;
                src_last  = want_last;
                #1;
                nvec++;
                if (eng_valid !== 1'b1 || src_ready !== 1'b0 || busy !== 1'b1 ||
                    done_pulse !== 1'b0) begin
                    nerr++;
                    $display("FAIL stall blk=%0d got ev=%b sr=%b busy=%b dp=%b want 1 0 1 0",
                             i, eng_valid, src_ready, busy, done_pulse);
                end
            end
            tick();
            idle_inputs();
            src_valid = 1'b1;
            eng_ready = 1'b1;
            src_last  = want_last ^ (i == mism_idx);
            if (i == mism_idx) exp_err_last = 1'b1;
            if (coincident && want_last) digest_valid = 1'b1;
            #1;
            nvec++;
            if (eng_last !== want_last || eng_valid !== 1'b1 || src_ready !== 1'b1) begin
                nerr++;
                $display("FAIL handshake blk=%0d/%0d got last=%b ev=%b sr=%b want last=%b 1 1",
                         i, nblk, eng_last, eng_valid, src_ready, want_last);
            end
        end
        if (!coincident) begin
            for (int g = 0; g < digest_gap; g++) begin
                tick();
                idle_inputs();
                src_valid = 1'b1;
                eng_ready = 1'b1;
                #1;
                nvec++;
                if (eng_valid !== 1'b0 || src_ready !== 1'b0 || busy !== 1'b1 ||
                    done_pulse !== 1'b0) begin
                    nerr++;
                    $display("FAIL wait_digest got ev=%b sr=%b busy=%b dp=%b want 0 0 1 0",
                             eng_valid, src_ready, busy, done_pulse);
                end
            end
            tick();
            idle_inputs();
            digest_valid = 1'b1;
        end
        tick();
        idle_inputs();
        #1;
        nvec++;
        if (done_pulse !== 1'b1 || busy !== 1'b1 || cfg_ready !== 1'b0) begin
            nerr++;
            $display("FAIL done_pulse got dp=%b busy=%b cr=%b want 1 1 0",
                     done_pulse, busy, cfg_ready);
        end
        exp_jobs = (exp_jobs + 1) % (1 << JOBCNTWIDTH);
        tick();
        #1;
        nvec++;
        if (done_pulse !== 1'b0 || cfg_ready !== 1'b1 || busy !== 1'b0 ||
            jobs_done !== JOBCNTWIDTH'(exp_jobs) || err_last_mismatch !== exp_err_last) begin
            nerr++;
            $display("FAIL job_end got dp=%b cr=%b busy=%b jobs=%0d errl=%b want 0 1 0 %0d %b",
                     done_pulse, cfg_ready, busy, jobs_done, err_last_mismatch,
                     exp_jobs, exp_err_last);
        end
    endtask

    task automatic clear_errors();
        tick();
        idle_inputs();
        err_clear = 1'b1;
        tick();
        idle_inputs();
        exp_err_last = 1'b0;
        exp_err_spur = 1'b0;
        #1;
        nvec++;
        if (err_last_mismatch !== 1'b0 || err_spurious_digest !== 1'b0) begin
            nerr++;
            $display("FAIL err_clear got errl=%b errs=%b want 0 0",
                     err_last_mismatch, err_spurious_digest);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        nvec++;
        if (cfg_ready !== 1'b1 || src_ready !== 1'b0 || eng_valid !== 1'b0 ||
            eng_last !== 1'b0 || in_data_req !== 1'b0 || out_data_req !== 1'b0 ||
            busy !== 1'b0 || done_pulse !== 1'b0 || jobs_done !== '0 ||
            err_last_mismatch !== 1'b0 || err_spurious_digest !== 1'b0) begin
            nerr++;
            $display("FAIL %s got cr=%b sr=%b ev=%b el=%b ireq=%b oreq=%b busy=%b dp=%b jobs=%0d el=%b es=%b want 1 0 0 0 0 0 0 0 0 0 0",
                     tag, cfg_ready, src_ready, eng_valid, eng_last, in_data_req,
                     out_data_req, busy, done_pulse, jobs_done, err_last_mismatch,
                     err_spurious_digest);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        cfg_size       = '0;
        out_fifo_level = '0;
        HRESETn        = 1'b0;
        repeat (3) tick();
        #1;
        check_reset_outputs("reset_low");
        HRESETn = 1'b1;
        tick();
        #1;
        check_reset_outputs("reset_released");
        exp_jobs     = 0;
        exp_err_last = 1'b0;
        exp_err_spur = 1'b0;
    endtask

    task automatic test_single_block();
        do_job(512, 0, -1, 70, 1'b0);
    endtask

    task automatic test_multi_block_stalls();
        // 1025 bits -> 3 blocks, with varied engine back-pressure
        do_job(1025, 5, -1, 2, 1'b0);
        do_job(1025, 2, -1, 0, 1'b0);
    endtask

    task automatic test_zero_and_mismatch();
        do_job(0, 1, -1, 1, 1'b0);
        do_job(1024, 1, 0, 1, 1'b0);
        clear_errors();
    endtask

    task automatic test_spurious_digest();
        tick();
        idle_inputs();
        digest_valid = 1'b1;
        exp_err_spur = 1'b1;
        tick();
        idle_inputs();
        #1;
        nvec++;
        if (err_spurious_digest !== exp_err_spur || busy !== 1'b0 || done_pulse !== 1'b0 ||
            jobs_done !== JOBCNTWIDTH'(exp_jobs)) begin
            nerr++;
            $display("FAIL spurious_digest got es=%b busy=%b dp=%b jobs=%0d want 1 0 0 %0d",
                     err_spurious_digest, busy, done_pulse, jobs_done, exp_jobs);
        end
        clear_errors();
    endtask

    task automatic test_digest_coincident();
        do_job(1536, 1, -1, 0, 1'b1);
    endtask

    task automatic test_abort();
        tick();
        idle_inputs();
        cfg_size  = 2048;
        cfg_valid = 1'b1;
        tick();
        idle_inputs();
        src_valid = 1'b1;
        eng_ready = 1'b1;
        tick();
        idle_inputs();
        tick();
        idle_inputs();
        #1;
        nvec++;
        if (in_data_req !== 1'b1) begin
            nerr++;
            $display("FAIL in_data_req_stream got=%b want=1", in_data_req);
        end
        ctrl_abort = 1'b1;
        tick();
        idle_inputs();
        #1;
        nvec++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0 || done_pulse !== 1'b0) begin
            nerr++;
            $display("FAIL abort_idle got cr=%b busy=%b dp=%b want 1 0 0",
                     cfg_ready, busy, done_pulse);
        end
        tick();
        #1;
        nvec++;
        if (done_pulse !== 1'b0 || in_data_req !== 1'b0 || jobs_done !== JOBCNTWIDTH'(exp_jobs)) begin
            nerr++;
            $display("FAIL abort_after got dp=%b ireq=%b jobs=%0d want 0 0 %0d",
                     done_pulse, in_data_req, jobs_done, exp_jobs);
        end
        do_job(512, 0, -1, 3, 1'b0);
    endtask

    task automatic test_out_req();
        logic [FIFOLVLWIDTH-1:0] lvls [4];
        lvls[0] = 3'd0;
        lvls[1] = 3'd1;
        lvls[2] = 3'd0;
        lvls[3] = 3'd5;
        for (int i = 0; i < 4; i++) begin
            tick();
            out_fifo_level = lvls[i];
            tick();
            #1;
            nvec++;
            if (out_data_req !== (int'(lvls[i]) >= OUTREQTHRESH)) begin
                nerr++;
                $display("FAIL out_data_req lvl=%0d got=%b want=%b",
                         lvls[i], out_data_req, (int'(lvls[i]) >= OUTREQTHRESH));
            end
        end
    endtask

    task automatic test_reset_midjob();
        out_fifo_level = 3'd7;
        tick();
        idle_inputs();
        digest_valid = 1'b1;
        tick();
        idle_inputs();
        cfg_size  = 1024;
        cfg_valid = 1'b1;
        tick();
        idle_inputs();
        src_valid = 1'b1;
        src_last  = 1'b1;
        eng_ready = 1'b1;
        tick();
        src_last  = 1'b0;
        eng_ready = 1'b0;
        #1;
        nvec++;
        if (busy !== 1'b1 || err_last_mismatch !== 1'b1 || out_data_req !== 1'b1) begin
            nerr++;
            $display("FAIL pre_reset got busy=%b errl=%b oreq=%b want 1 1 1",
                     busy, err_last_mismatch, out_data_req);
        end
        HRESETn = 1'b0;
        #1;
        check_reset_outputs("reset_midjob_immediate");
        tick();
        #1;
        check_reset_outputs("reset_midjob_held");
        idle_inputs();
        out_fifo_level = '0;
        HRESETn        = 1'b1;
        exp_jobs     = 0;
        exp_err_last = 1'b0;
        exp_err_spur = 1'b0;
        do_job(512, 1, -1, 2, 1'b0);
    endtask

    task automatic test_random();
        longint unsigned sz;
        int nb;
        int mism;
        for (int j = 0; j < 12; j++) begin
            sz   = longint'($urandom_range(0, 4000));
            nb   = model_blocks(sz);
            mism = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nb - 1) : -1;
            do_job(sz, 3, mism, $urandom_range(0, 5), bit'($urandom_range(0, 1)));
            if (exp_err_last) clear_errors();
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_multi_block_stalls();
        test_zero_and_mismatch();
        test_spurious_digest();
        test_digest_coincident();
        test_abort();
        test_out_req();
        test_reset_midjob();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/wrapper_sha256_job_ctrl.md
Name: wrapper_sha256_job_ctrl

Overview:
- Per-message sequencer between the AHB packet constructor (input port) and the sha256_stream engine.
- Accepts a message-length job descriptor and gates 512-bit blocks into the engine.
- Counts blocks and forces the engine's last flag on the final block.
- Waits for the message digest, raises a done pulse, and drives the DMA in/out data request lines.

Parameters:
- CFGSIZEWIDTH, 64: width of the job message size in bits (padded message length).
- FIFOLVLWIDTH, 3: width of the output FIFO occupancy input.
- OUTREQTHRESH, 1: output FIFO level at or above which out_data_req asserts.
- JOBCNTWIDTH, 16: width of the completed-job counter.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  reset, asynchronous, active-low
- cfg_size  in  CFGSIZEWIDTH  message length in bits
- cfg_valid  in  1  job descriptor valid
- cfg_ready  out  1  job descriptor accepted when high with cfg_valid
- src_valid  in  1  block valid from packet constructor
- src_last  in  1  constructor's last flag
- src_ready  out  1  ready to constructor
- eng_valid  out  1  block valid to engine
- eng_last  out  1  last flag to engine
- eng_ready  in  1  engine ready
- digest_valid  in  1  single-cycle pulse, final message digest produced (payload-filtered)
- out_fifo_level  in  FIFOLVLWIDTH  output FIFO occupancy
- ctrl_abort  in  1  soft abort of current job
- err_clear  in  1  clears sticky error flags
- in_data_req  out  1  DMA input request
- out_data_req  out  1  DMA output request
- busy  out  1  job in progress
- done_pulse  out  1  one cycle on job completion
- jobs_done  out  JOBCNTWIDTH  completed-job count, wraps
- err_last_mismatch  out  1  sticky: src_last disagreed with block count
- err_spurious_digest  out  1  sticky: digest_valid outside a job

Behaviour:
- Reset values: state IDLE, cfg_ready=1, src_ready=0, eng_valid=0, eng_last=0, in_data_req=0, out_data_req=0, busy=0, done_pulse=0, jobs_done=0, both error flags=0, block counter=0.
- Block count on acceptance: blocks = cfg_size[CFGSIZEWIDTH-1:9] + (|cfg_size[8:0]). If the result is 0, blocks = 1. Counter width is CFGSIZEWIDTH-8 so ceil never overflows.
- States:
  - IDLE: cfg_ready=1. On cfg_valid, latch remaining=blocks and go to STREAM.
  - STREAM: combinational pass-through eng_valid=src_valid, src_ready=eng_ready, eng_last=(remaining==1). Each handshake (src_valid & eng_ready) decrements remaining. The handshake with remaining==1 goes to WAIT_DIGEST; if digest_valid is also high that cycle, go straight to DONE.
  - WAIT_DIGEST: src_ready=0, eng_valid=0. On digest_valid go to DONE.
  - DONE: done_pulse=1 for exactly one cycle, jobs_done+1 (wraps at 2^JOBCNTWIDTH), then IDLE.
- busy=1 in STREAM, WAIT_DIGEST and DONE. cfg_ready=0 outside IDLE. Back-to-back jobs: the next cfg can be accepted the cycle after DONE.
- Count is authoritative. On a STREAM handshake where src_last != (remaining==1), set err_last_mismatch; the block is still passed and eng_last follows the count.
- digest_valid in IDLE sets err_spurious_digest and is otherwise ignored.
- err_clear clears both flags next cycle. A set event in the same cycle wins over clear.
- ctrl_abort in STREAM or WAIT_DIGEST: go to IDLE next cycle, remaining=0, no done_pulse, jobs_done unchanged. A handshake in the abort cycle still completes. ctrl_abort in IDLE or DONE has no effect.
- in_data_req is registered: next value = (state==STREAM) & ~src_valid & (remaining!=0). One cycle latency.
- out_data_req is registered: next value = (out_fifo_level >= OUTREQTHRESH). One cycle latency; independent of state and abort.
- HRESETn asserted mid-job returns every output to its reset value immediately; an in-flight block is dropped.

Test Plan:
- Reset, then cfg_size=512 with one src block (src_last=1) and digest_valid 70 cycles later -> eng_last=1 on the handshake; done_pulse 1 cycle later than the digest; jobs_done=1; flags 0.
- cfg_size=1025 -> 3 blocks; eng_last high only on the 3rd handshake. Apply eng_ready stalls of 0/2/5 cycles -> no block lost or duplicated, remaining 3→2→1→0.
- cfg_size=0 -> 1 block. Then 2nd job with src_last=1 on block 1 of 2 -> err_last_mismatch=1, eng_last=0 on that block; err_clear -> 0.
- digest_valid in IDLE -> err_spurious_digest=1. Separately, digest_valid coincident with the final handshake -> DONE next cycle.
- ctrl_abort during STREAM after 1 of 4 blocks -> IDLE next cycle, cfg_ready=1, no done_pulse. A subsequent cfg_size=512 job completes normally.
- out_fifo_level 0→1→0 with OUTREQTHRESH=1 -> out_data_req follows one cycle later. HRESETn low mid-STREAM -> all outputs at reset values while low.
